// File: rtl/score_board_if.sv
// ----------------------------------------------------------------------------
// score_board_if
//   Bundle between the issue queue head and the score board.
//   Signals:
//     flush          discard all in-flight producer tracking
//     issue_valid    [1:0]      per-lane issue request (lane 0 older)
//     issue_wen      [1:0]      per-lane "writes a destination register"
//     issue_is_load  [1:0]      per-lane result only available from MEM
//     issue_dst      [1:0][4:0] per-lane destination register
//     issue_src      [3:0][4:0] source registers, index 2*lane+k
//     src_sel        [3:0][2:0] operand source select per source
//     issue_accept   [1:0]      per-lane issue granted this cycle
//     pop_number     [1:0]      number of accepted lanes (0..2)
//     stall_count    [STALL_CNT_W-1:0] lane-0 stall cycle statistic
//   Modports: master (issue queue side), slave (score board side).
// ----------------------------------------------------------------------------
interface score_board_if #(
    parameter int STALL_CNT_W = 32
);
    logic                   flush;
    logic [1:0]             issue_valid;
    logic [1:0]             issue_wen;
    logic [1:0]             issue_is_load;
    logic [1:0][4:0]        issue_dst;
    logic [3:0][4:0]        issue_src;
    logic [3:0][2:0]        src_sel;
    logic [1:0]             issue_accept;
    logic [1:0]             pop_number;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output flush, issue_valid, issue_wen, issue_is_load, issue_dst, issue_src,
        input  src_sel, issue_accept, pop_number, stall_count
    );

    modport slave (
        input  flush, issue_valid, issue_wen, issue_is_load, issue_dst, issue_src,
        output src_sel, issue_accept, pop_number, stall_count
    );
endinterface

// File: rtl/score_board.sv
// ----------------------------------------------------------------------------
// score_board
//   Dual-issue register score board. Tracks the youngest in-flight producer of
//   every architectural register (1..31) through EX -> MEM -> CMT, selects the
//   forwarding source for each of the four issuing operands and grants issue
//   strictly in order, stalling on load-use and intra-pair RAW hazards.
//
//   Ports:
//     clk   input   single clock, rising edge
//     rst   input   synchronous, active-high reset
//     sb    score_board_if.slave  issue request / operand select bundle
//
//   Optional feature:
//     SCORE_BOARD_STATS_EN  when defined, stall_count counts cycles where lane 0
//                           was valid but not accepted (saturating); otherwise
//                           stall_count is tied to zero.
// ----------------------------------------------------------------------------
module score_board #(
    parameter int STALL_CNT_W = 32
) (
    input logic          clk,
    input logic          rst,
    score_board_if.slave sb
);

    typedef enum logic [1:0] {
        ST_EX  = 2'd0,
        ST_MEM = 2'd1,
        ST_CMT = 2'd2
    } stage_e;

    localparam logic [2:0] SEL_RF    = 3'd0;
    localparam logic [2:0] SEL_EX0   = 3'd1;
    localparam logic [2:0] SEL_MEM0  = 3'd3;
    localparam logic [2:0] SEL_CMT0  = 3'd5;
    localparam logic [2:0] SEL_STALL = 3'd7;

    // Entry 0 is never written, so it stays invalid after reset.
    logic   valid_q [32];
    logic   valid_d [32];
    stage_e stage_q [32];
    stage_e stage_d [32];
    logic   lane_q  [32];
    logic   lane_d  [32];
    logic   load_q  [32];
    logic   load_d  [32];

    logic [3:0][2:0] sel_c;
    logic [1:0]      accept_c;
    logic            raw_c;

    // Operand source selection from the current entry of each source register.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sel_c[i] = SEL_RF;
            if (sb.issue_src[i] != 5'd0 && valid_q[sb.issue_src[i]]) begin
                case (stage_q[sb.issue_src[i]])
                    ST_EX:   sel_c[i] = load_q[sb.issue_src[i]] ? SEL_STALL
                                      : SEL_EX0 + 3'(lane_q[sb.issue_src[i]]);
                    ST_MEM:  sel_c[i] = SEL_MEM0 + 3'(lane_q[sb.issue_src[i]]);
                    default: sel_c[i] = SEL_CMT0 + 3'(lane_q[sb.issue_src[i]]);
                endcase
            end
        end
    end

    // Lane 1 may not consume lane 0's result in the same cycle.
    assign raw_c = sb.issue_wen[0] && (sb.issue_dst[0] != 5'd0) &&
                   ((sb.issue_src[2] == sb.issue_dst[0]) ||
                    (sb.issue_src[3] == sb.issue_dst[0]));

    always_comb begin
        accept_c[0] = !rst && sb.issue_valid[0] &&
                      (sel_c[0] != SEL_STALL) && (sel_c[1] != SEL_STALL);
        accept_c[1] = accept_c[0] && sb.issue_valid[1] && !raw_c &&
                      (sel_c[2] != SEL_STALL) && (sel_c[3] != SEL_STALL);
    end

    assign sb.src_sel      = sel_c;
    assign sb.issue_accept = accept_c;
    assign sb.pop_number   = {1'b0, accept_c[0]} + {1'b0, accept_c[1]};

    // Next state: advance every entry, then overlay new producers. Lane 1 is
    // applied last so it wins a same-register write within one pair.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            valid_d[r] = 1'b0;
            stage_d[r] = stage_q[r];
            lane_d[r]  = lane_q[r];
            load_d[r]  = load_q[r];
            if (valid_q[r]) begin
                case (stage_q[r])
                    ST_EX: begin
                        valid_d[r] = 1'b1;
                        stage_d[r] = ST_MEM;
                    end
                    ST_MEM: begin
                        valid_d[r] = 1'b1;
                        stage_d[r] = ST_CMT;
                    end
                    default: valid_d[r] = 1'b0;
                endcase
            end
        end
        for (int l = 0; l < 2; l++) begin
            if (accept_c[l] && sb.issue_wen[l] && sb.issue_dst[l] != 5'd0) begin
                valid_d[sb.issue_dst[l]] = 1'b1;
                stage_d[sb.issue_dst[l]] = ST_EX;
                lane_d[sb.issue_dst[l]]  = 1'(l);
                load_d[sb.issue_dst[l]]  = sb.issue_is_load[l];
            end
        end
    end

    // Flush shares the reset path for the valid bits, overriding new issues.
    always_ff @(posedge clk) begin
        for (int r = 0; r < 32; r++) begin
            if (rst || sb.flush) begin
                valid_q[r] <= 1'b0;
            end else begin
                valid_q[r] <= valid_d[r];
            end
        end
    end

    // Entry payload is only meaningful while valid, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int r = 0; r < 32; r++) begin
            stage_q[r] <= stage_d[r];
            lane_q[r]  <= lane_d[r];
            load_q[r]  <= load_d[r];
        end
    end

`ifdef SCORE_BOARD_STATS_EN
    logic [STALL_CNT_W-1:0] stall_q;
    logic [STALL_CNT_W-1:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if (sb.issue_valid[0] && !accept_c[0] && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign sb.stall_count = stall_q;
`else
    assign sb.stall_count = '0;
`endif

endmodule

// File: tb/tb_score_board.sv
module tb_score_board;

    localparam int W = 32;
`ifdef SCORE_BOARD_STATS_EN
    localparam int ST = 1;
`else
    localparam int ST = 0;
`endif

    typedef struct {
        string         tag;
        logic [11:0]   sel;
        logic [1:0]    acc;
        logic [1:0]    pop;
        logic [W-1:0]  stall;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    score_board_if #(.STALL_CNT_W(W)) bus ();

    score_board #(.STALL_CNT_W(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Drive one cycle of stimulus, push the expected response, then pop and
    // compare once the combinational outputs settle.
    task automatic cyc(input string tag, input logic r, input logic fl,
                       input logic [1:0] v, input logic [1:0] wen, input logic [1:0] ld,
                       input logic [4:0] d1, input logic [4:0] d0,
                       input logic [4:0] s3, input logic [4:0] s2,
                       input logic [4:0] s1, input logic [4:0] s0,
                       input logic [2:0] e3, input logic [2:0] e2,
                       input logic [2:0] e1, input logic [2:0] e0,
                       input logic [1:0] eacc, input logic [1:0] epop,
                       input int estall);
        exp_t e;
        exp_t got;
        rst                = r;
        bus.flush          = fl;
        bus.issue_valid    = v;
        bus.issue_wen      = wen;
        bus.issue_is_load  = ld;
        bus.issue_dst      = {d1, d0};
        bus.issue_src      = {s3, s2, s1, s0};
        e.tag   = tag;
        e.sel   = {e3, e2, e1, e0};
        e.acc   = eacc;
        e.pop   = epop;
        e.stall = W'(estall);
        sb_q.push_back(e);
        #1;
        got = sb_q.pop_front();
        total_cnt++;
        assert (bus.src_sel === got.sel) pass_cnt++;
        else $error("FAIL %s src_sel got=%h exp=%h", got.tag, bus.src_sel, got.sel);
        total_cnt++;
        assert (bus.issue_accept === got.acc) pass_cnt++;
        else $error("FAIL %s accept got=%b exp=%b", got.tag, bus.issue_accept, got.acc);
        total_cnt++;
        assert (bus.pop_number === got.pop) pass_cnt++;
        else $error("FAIL %s pop got=%0d exp=%0d", got.tag, bus.pop_number, got.pop);
        total_cnt++;
        assert (bus.stall_count === got.stall) pass_cnt++;
        else $error("FAIL %s stall got=%0d exp=%0d", got.tag, bus.stall_count, got.stall);
        @(negedge clk);
    endtask

    initial begin
        rst               = 1'b1;
        bus.flush         = 1'b0;
        bus.issue_valid   = 2'b11;
        bus.issue_wen     = 2'b11;
        bus.issue_is_load = 2'b00;
        bus.issue_dst     = {5'd5, 5'd5};
        bus.issue_src     = '0;
        @(negedge clk);

        //   tag         rst fl  v      wen    ld     d1  d0  s3 s2 s1 s0  e3 e2 e1 e0 acc    pop  stall
        cyc("reset",      1, 0, 2'b11, 2'b11, 2'b00, 5,  5,  0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 0, 0);
        // ALU forwarding chain on r5
        cyc("alu_issue",  0, 0, 2'b01, 2'b01, 2'b00, 0,  5,  0, 0, 0, 0,  0, 0, 0, 0, 2'b01, 1, 0);
        cyc("alu_ex0",    0, 0, 2'b01, 2'b00, 2'b00, 0,  0,  0, 0, 0, 5,  0, 0, 0, 1, 2'b01, 1, 0);
        cyc("alu_mem0",   0, 0, 2'b01, 2'b00, 2'b00, 0,  0,  0, 0, 0, 5,  0, 0, 0, 3, 2'b01, 1, 0);
        cyc("alu_cmt0",   0, 0, 2'b01, 2'b00, 2'b00, 0,  0,  0, 0, 0, 5,  0, 0, 0, 5, 2'b01, 1, 0);
        cyc("alu_done",   0, 0, 2'b01, 2'b00, 2'b00, 0,  0,  0, 0, 0, 5,  0, 0, 0, 0, 2'b01, 1, 0);
        // load-use on r7 produced by lane 1
        cyc("ld_issue",   0, 0, 2'b11, 2'b10, 2'b10, 7,  0,  0, 0, 0, 0,  0, 0, 0, 0, 2'b11, 2, 0);
        cyc("ld_stall",   0, 0, 2'b01, 2'b00, 2'b00, 0,  0,  0, 0, 0, 7,  0, 0, 0, 7, 2'b00, 0, 0);
        cyc("ld_mem1",    0, 0, 2'b01, 2'b00, 2'b00, 0,  0,  0, 0, 0, 7,  0, 0, 0, 4, 2'b01, 1, ST);
        cyc("ld_cmt1",    0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0, 0, 0, 7,  0, 0, 0, 6, 2'b00, 0, ST);
        // intra-pair RAW on r3
        cyc("raw_pair",   0, 0, 2'b11, 2'b01, 2'b00, 0,  3,  0, 3, 0, 7,  0, 0, 0, 0, 2'b01, 1, ST);
        // WAW: both lanes write r9, lane 1 wins
        cyc("waw_pair",   0, 0, 2'b11, 2'b11, 2'b00, 9,  9,  0, 0, 0, 3,  0, 0, 0, 1, 2'b11, 2, ST);
        cyc("waw_ex1",    0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0, 0, 3, 9,  0, 0, 3, 2, 2'b00, 0, ST);
        // WAW across cycles: lane 0 then lane 1 rewrites r9
        cyc("waw_l0",     0, 0, 2'b01, 2'b01, 2'b00, 0,  9,  0, 0, 0, 0,  0, 0, 0, 0, 2'b01, 1, ST);
        cyc("waw_l1",     0, 0, 2'b11, 2'b10, 2'b00, 9,  0,  0, 0, 0, 9,  0, 0, 0, 1, 2'b11, 2, ST);
        cyc("waw_young",  0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0, 0, 0, 9,  0, 0, 0, 2, 2'b00, 0, ST);
        // flush discards r4 and the issue made during the flush
        cyc("fl_setup",   0, 0, 2'b01, 2'b01, 2'b00, 0,  4,  0, 0, 0, 0,  0, 0, 0, 0, 2'b01, 1, ST);
        cyc("fl_cycle",   0, 1, 2'b01, 2'b01, 2'b00, 0,  4,  0, 0, 0, 4,  0, 0, 0, 1, 2'b01, 1, ST);
        cyc("fl_after",   0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0, 0, 9, 4,  0, 0, 0, 0, 2'b00, 0, ST);
        // mid-operation reset abandons r4 and clears the counter
        cyc("rst_setup",  0, 0, 2'b01, 2'b01, 2'b00, 0,  4,  0, 0, 0, 0,  0, 0, 0, 0, 2'b01, 1, ST);
        cyc("rst_cycle",  1, 0, 2'b01, 2'b01, 2'b00, 0,  4,  0, 0, 0, 4,  0, 0, 0, 1, 2'b00, 0, ST);
        cyc("rst_after",  0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  0, 0, 0, 4,  0, 0, 0, 0, 2'b00, 0, 0);
        // register zero is never tracked
        cyc("r0_write",   0, 0, 2'b01, 2'b01, 2'b00, 0,  0,  0, 0, 0, 0,  0, 0, 0, 0, 2'b01, 1, 0);
        cyc("r0_read",    0, 0, 2'b01, 2'b00, 2'b00, 0,  0,  0, 0, 0, 0,  0, 0, 0, 0, 2'b01, 1, 0);

        total_cnt++;
        assert (sb_q.size() == 0) pass_cnt++;
        else $error("FAIL queue_drain got=%0d exp=0", sb_q.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
